cache_bus_ctrl: RTL and testbench

CACHE_BUS_CTRL -- requirements
Module: cache_bus_ctrl

---
 rtl/cache_bus_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cache_bus_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_ctrl.sv
// Snooping-bus transaction controller for NCACHE MESI caches: round-robin grant, snoop broadcast,
// write-back and memory read phases. Define BUS_TIMEOUT_EN to add the memory-phase watchdog.
module cache_bus_ctrl #(
    parameter int NCACHE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCACHE-1:0] req_rd,
    input  logic [NCACHE-1:0] req_rdx,
    input  logic [NCACHE-1:0] req_upgr,
    input  logic [NCACHE-1:0] flush_in,
    input  logic [NCACHE-1:0] c_in,
    input  logic              mem_ack,
    output logic [NCACHE-1:0] grant,
    output logic [NCACHE-1:0] snp_rd,
    output logic [NCACHE-1:0] snp_rdx,
    output logic [NCACHE-1:0] snp_upgr,
    output logic [NCACHE-1:0] shared_out,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              done,
    output logic              err
);
    localparam int IW = (NCACHE > 1) ? $clog2(NCACHE) : 1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_SAMPLE, S_WB, S_MEMRD, S_DONE
    } state_t;

    typedef enum logic [1:0] {C_RD, C_RDX, C_UPGR} cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [NCACHE-1:0] own_q, own_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_q, last_d;
    logic              shared_q, shared_d;
    logic              wb_q, wb_d;
    logic              tout_q, tout_d;
    logic              expired;

    logic [NCACHE-1:0] elig;
    logic [NCACHE-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              found;

    // Scan from last_owner+1 with wrap so every cache gets a fair turn.
    always_comb begin
        int j;
        logic [IW-1:0] jj;
        elig     = req_rd | req_rdx | req_upgr;
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        j        = 0;
        jj       = '0;
        for (int k = 0; k < NCACHE; k++) begin
            j = int'(last_q) + 1 + k;
            if (j >= NCACHE) j = j - NCACHE;
            jj = j[IW-1:0];
            if (!found && elig[jj]) begin
                found       = 1'b1;
                pick_idx    = jj;
                pick_oh[jj] = 1'b1;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Restarts on every entry into WB or MEMRD, counts while the phase is held.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_WB || state_q == S_MEMRD) && state_d == state_q)
            cnt_d = cnt_q + 1'b1;
    end

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        own_d      = own_q;
        idx_d      = idx_q;
        last_d     = last_q;
        shared_d   = shared_q;
        wb_d       = wb_q;
        tout_d     = tout_q;
        grant      = '0;
        snp_rd     = '0;
        snp_rdx    = '0;
        snp_upgr   = '0;
        shared_out = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    own_d  = pick_oh;
                    idx_d  = pick_idx;
                    tout_d = 1'b0;
                    if (req_rdx[pick_idx])       cmd_d = C_RDX;
                    else if (req_upgr[pick_idx]) cmd_d = C_UPGR;
                    else                         cmd_d = C_RD;
                    state_d = S_SNOOP;
                end
            end
            S_SNOOP: begin
                grant = own_q;
                unique case (cmd_q)
                    C_RDX:   snp_rdx  = ~own_q;
                    C_UPGR:  snp_upgr = ~own_q;
                    default: snp_rd   = ~own_q;
                endcase
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                grant    = own_q;
                shared_d = |(c_in & ~own_q);
                wb_d     = |(flush_in & ~own_q);
                if (wb_d)                 state_d = S_WB;
                else if (cmd_q == C_UPGR) state_d = S_DONE;
                else                      state_d = S_MEMRD;
            end
            S_WB: begin
                grant  = own_q;
                mem_wr = 1'b1;
                if (mem_ack) begin
                    state_d = (cmd_q == C_UPGR) ? S_DONE : S_MEMRD;
                end else if (expired) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_MEMRD: begin
                grant  = own_q;
                mem_rd = 1'b1;
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant      = own_q;
                done       = 1'b1;
                shared_out = (shared_q && !tout_q) ? own_q : '0;
                last_d     = idx_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    assign err = (state_q == S_DONE) && tout_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= C_RD;
            own_q    <= '0;
            idx_q    <= '0;
            last_q   <= IW'(NCACHE - 1);
            shared_q <= 1'b0;
            wb_q     <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            own_q    <= own_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            shared_q <= shared_d;
            wb_q     <= wb_d;
            tout_q   <= tout_d;
        end
    end
endmodule

// File: tb/tb_cache_bus_ctrl.sv
// Scoreboard bench for cache_bus_ctrl: stimulus pushes expected snoop/done records,
// a monitor pops and compares whenever the controller presents them.
module tb_cache_bus_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_rd, req_rdx, req_upgr, flush_in, c_in;
    logic         mem_ack;
    logic [N-1:0] grant, snp_rd, snp_rdx, snp_upgr, shared_out;
    logic         mem_rd, mem_wr, done, err;

    always #5 clk = ~clk;

    cache_bus_ctrl #(.NCACHE(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_rdx(req_rdx), .req_upgr(req_upgr),
        .flush_in(flush_in), .c_in(c_in), .mem_ack(mem_ack),
        .grant(grant), .snp_rd(snp_rd), .snp_rdx(snp_rdx), .snp_upgr(snp_upgr),
        .shared_out(shared_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .done(done), .err(err)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] shared;
        logic         err;
        int           glen;
        int           wr;
        int           rd;
    } done_t;

    typedef struct {
        logic [N-1:0] rd;
        logic [N-1:0] rdx;
        logic [N-1:0] upgr;
    } snp_t;

    done_t exp_done[$];
    snp_t  exp_snp[$];
    int    checks = 0;
    int    errors = 0;
    int    gcnt = 0, wcnt = 0, rcnt = 0;
    bit    ack_en = 1'b1;
    int    lat = 3;
    int    pcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {40'd0, grant, snp_rd, snp_rdx, snp_upgr, shared_out,
                mem_rd, mem_wr, done, err};
    endfunction

    task automatic push_done(input logic [N-1:0] g, input logic [N-1:0] s,
                             input logic e, input int gl, input int w, input int r);
        done_t d;
        d.grant = g; d.shared = s; d.err = e; d.glen = gl; d.wr = w; d.rd = r;
        exp_done.push_back(d);
    endtask

    task automatic push_snp(input logic [N-1:0] r, input logic [N-1:0] x,
                            input logic [N-1:0] u);
        snp_t s;
        s.rd = r; s.rdx = x; s.upgr = u;
        exp_snp.push_back(s);
    endtask

    // Memory model: acks on the (lat+1)-th cycle of each WB/MEMRD phase.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (mem_rd || mem_wr) && ack_en) begin
                if (pcnt == lat) begin
                    mem_ack = 1'b1;
                    pcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    pcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                pcnt = 0;
            end
        end
    end

    initial begin
        snp_t  s;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst) begin
                gcnt = 0; wcnt = 0; rcnt = 0;
            end else begin
                if (grant != '0) begin
                    gcnt++;
                    chk("grant_onehot", 64'($onehot(grant)), 64'd1);
                end
                if (mem_wr) wcnt++;
                if (mem_rd) rcnt++;
                if (mem_rd || mem_wr)
                    chk("mem_overlap", {63'd0, mem_rd & mem_wr}, 64'd0);
                if ((snp_rd | snp_rdx | snp_upgr) != '0) begin
                    if (exp_snp.size() == 0) begin
                        chk("snoop_unexpected", 64'd1, 64'd0);
                    end else begin
                        s = exp_snp.pop_front();
                        chk("snp_rd", 64'(snp_rd), 64'(s.rd));
                        chk("snp_rdx", 64'(snp_rdx), 64'(s.rdx));
                        chk("snp_upgr", 64'(snp_upgr), 64'(s.upgr));
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 64'd1, 64'd0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_grant", 64'(grant), 64'(d.grant));
                        chk("shared_out", 64'(shared_out), 64'(d.shared));
                        chk("err", 64'(err), 64'(d.err));
                        chk("grant_cycles", 64'(gcnt), 64'(d.glen));
                        chk("mem_wr_cycles", 64'(wcnt), 64'(d.wr));
                        chk("mem_rd_cycles", 64'(rcnt), 64'(d.rd));
                    end
                end else if (err) begin
                    chk("err_without_done", 64'(err), 64'd0);
                end
                if (grant == '0) begin
                    gcnt = 0; wcnt = 0; rcnt = 0;
                end
            end
        end
    end

    task automatic wait_grant();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 20);
        if (grant == '0) chk("grant_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < limit);
        if (!done) chk("done_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic run(input logic [N-1:0] r, input logic [N-1:0] x,
                       input logic [N-1:0] u, input logic [N-1:0] c,
                       input logic [N-1:0] f);
        @(negedge clk);
        req_rd = r; req_rdx = x; req_upgr = u; c_in = c; flush_in = f;
        wait_grant();
        req_rd = '0; req_rdx = '0; req_upgr = '0;
        wait_done(300);
        c_in = '0; flush_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 chk("reset_outputs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs(), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        req_rd = '0; req_rdx = '0; req_upgr = '0; c_in = '0; flush_in = '0;
        #1 chk("reset_outputs_t0", outs(), 64'd0);
        do_reset();

        push_snp(4'b1110, 4'b0000, 4'b0000);
        push_done(4'b0001, 4'b0000, 1'b0, 7, 0, 4);
        run(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        push_snp(4'b1101, 4'b0000, 4'b0000);
        push_done(4'b0010, 4'b0010, 1'b0, 7, 0, 4);
        run(4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000);

        push_snp(4'b0000, 4'b1110, 4'b0000);
        push_done(4'b0001, 4'b0000, 1'b0, 11, 4, 4);
        run(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1000);

        push_snp(4'b0000, 4'b0000, 4'b1011);
        push_done(4'b0100, 4'b0000, 1'b0, 3, 0, 0);
        run(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

        push_snp(4'b0000, 4'b0000, 4'b1101);
        push_done(4'b0010, 4'b0000, 1'b0, 7, 4, 0);
        run(4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001);

        push_snp(4'b0111, 4'b0000, 4'b0000);
        push_done(4'b1000, 4'b0000, 1'b0, 7, 0, 4);
        run(4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);

        push_snp(4'b0000, 4'b1110, 4'b0000);
        push_done(4'b0001, 4'b0000, 1'b0, 7, 0, 4);
        run(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);

`ifdef BUS_TIMEOUT_EN
        ack_en = 1'b0;
        push_snp(4'b1110, 4'b0000, 4'b0000);
        push_done(4'b0001, 4'b0000, 1'b1, 67, 0, 64);
        run(4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        ack_en = 1'b1;
`endif

        push_snp(4'b0000, 4'b0000, 4'b1011);
        push_done(4'b0100, 4'b0000, 1'b0, 3, 0, 0);
        run(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

        ack_en = 1'b0;
        push_snp(4'b1110, 4'b0000, 4'b0000);
        @(negedge clk);
        req_rd = 4'b0001;
        wait_grant();
        req_rd = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rd && n < 20);
        chk("memrd_reached", {63'd0, mem_rd}, 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("abort_outputs", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;

        push_snp(4'b1011, 4'b0000, 4'b0000);
        push_done(4'b0100, 4'b0000, 1'b0, 7, 0, 4);
        run(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        do_reset();
        for (int t = 0; t < N; t++) begin
            push_snp(~(4'b0001 << t), 4'b0000, 4'b0000);
            push_done(4'b0001 << t, 4'b0000, 1'b0, 7, 0, 4);
        end
        @(negedge clk);
        req_rd = 4'b1111;
        for (int t = 0; t < N; t++) wait_done(100);
        req_rd = '0;
        repeat (5) @(negedge clk);

        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
        chk("snoop_queue_empty", 64'(exp_snp.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
